// File: rtl/xor_accum_pipe.sv
// Registered XOR datapath over a valid/ready handshake.
// Pairwise mode emits a^b per beat; accumulate mode folds a^b across a packet.
module xor_accum_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             clr,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_parity_q, out_parity_d;
  logic [CNT_W-1:0]   out_beats_q, out_beats_d;
  logic               out_sat_q, out_sat_d;

  logic               accept;
  logic [WIDTH-1:0]   beat_x;
  logic [WIDTH-1:0]   fold_x;
  logic [CNT_W-1:0]   cnt_inc;
  logic               sat_inc;
  logic               load;
  logic [WIDTH-1:0]   res_data;
  logic [CNT_W-1:0]   res_beats;
  logic               res_sat;

  assign in_ready = (!out_valid_q || out_ready) && !clr;
  assign accept   = in_valid && in_ready;
  assign beat_x   = in_a ^ in_b;
  assign fold_x   = acc_q ^ beat_x;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  assign sat_inc  = sat_q || (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    load      = 1'b0;
    res_data  = '0;
    res_beats = '0;
    res_sat   = 1'b0;

    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (!mode || in_last) begin
            load      = 1'b1;
            res_data  = beat_x;
            res_beats = CNT_ONE;
            res_sat   = 1'b0;
          end else begin
            acc_d   = beat_x;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
            state_d = ACC;
          end
        end
        ACC: begin
          if (in_last) begin
            load      = 1'b1;
            res_data  = fold_x;
            res_beats = cnt_inc;
            res_sat   = sat_inc;
            acc_d     = '0;
            cnt_d     = '0;
            sat_d     = 1'b0;
            state_d   = IDLE;
          end else begin
            acc_d = fold_x;
            cnt_d = cnt_inc;
            sat_d = sat_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output register: a new result wins over a drain in the same cycle.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_beats_d  = out_beats_q;
    out_sat_d    = out_sat_q;
    if (out_ready)
      out_valid_d = 1'b0;
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = res_data;
      out_parity_d = ^res_data;
      out_beats_d  = res_beats;
      out_sat_d    = res_sat;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
      out_beats_q  <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_beats_q  <= out_beats_d;
      out_sat_q    <= out_sat_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign out_beats  = out_beats_q;
  assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_xor_accum_pipe.sv
// Randomised and directed bench for xor_accum_pipe against a packet-level model
// that keeps the beats of the open packet in a queue and folds them on the last beat.
module tb_xor_accum_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             resetb;
  logic             clr;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic [CNT_W-1:0] out_beats;
  logic             out_sat;

  xor_accum_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetb(resetb), .clr(clr), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_parity(out_parity), .out_beats(out_beats),
    .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               beats;
    logic             sat;
  } res_t;

  res_t             expq[$];
  logic [WIDTH-1:0] pkt[$];
  bit               in_pkt;
  int               tests_run;
  int               tests_failed;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic void pushResult();
    res_t r;
    r.data = '0;
    foreach (pkt[i]) r.data = r.data ^ pkt[i];
    r.beats = (pkt.size() > MAXC) ? MAXC : pkt.size();
    r.sat   = pkt.size() > MAXC;
    expq.push_back(r);
    pkt.delete();
    in_pkt = 0;
  endfunction

  function automatic void modelBeat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic m, input logic l);
    pkt.push_back(a ^ b);
    if (!in_pkt && (!m || l)) pushResult();
    else if (!in_pkt) in_pkt = 1;
    else if (l) pushResult();
  endfunction

  // One cycle: drive at negedge, sample 1ns later, then advance the model to the next posedge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic m, input logic l, input logic c, input logic r);
    bit exp_ready;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; mode = m; in_last = l; clr = c; out_ready = r;
    #1;
    exp_ready = (expq.size() == 0 || r) && !c;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(expq.size() != 0));
    if (expq.size() != 0) begin
      checkOutput("out_data", 32'(out_data), 32'(expq[0].data));
      checkOutput("out_parity", 32'(out_parity), 32'(^expq[0].data));
      checkOutput("out_beats", 32'(out_beats), 32'(expq[0].beats));
      checkOutput("out_sat", 32'(out_sat), 32'(expq[0].sat));
    end
    if (expq.size() != 0 && r) void'(expq.pop_front());
    if (c) begin
      pkt.delete();
      in_pkt = 0;
    end else if (v && exp_ready) begin
      modelBeat(a, b, m, l);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; in_pkt = 0;
    resetb = 1'b0; clr = 0; mode = 0; in_valid = 0; in_a = '0; in_b = '0; in_last = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;

    // Pairwise single beat: A5^0E = AB, five ones so odd parity.
    applyStimulus(1, 8'hA5, 8'h0E, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1);
    checkOutput("pw_data", 32'(out_data), 32'h000000AB);
    checkOutput("pw_parity", 32'(out_parity), 32'd1);

    // Three-beat accumulate packet folds to 3F with even parity.
    applyStimulus(1, 8'h01, 8'h02, 1, 0, 0, 1);
    applyStimulus(1, 8'h04, 8'h08, 1, 0, 0, 1);
    applyStimulus(1, 8'h10, 8'h20, 0, 1, 0, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1);
    checkOutput("acc_data", 32'(out_data), 32'h0000003F);
    checkOutput("acc_beats", 32'(out_beats), 32'd3);

    // Backpressure then four back-to-back pairwise results.
    applyStimulus(1, 8'h33, 8'h0F, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'hEE, 8'h11, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'(i * 17), 8'h5A, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1);

    // Twenty-beat packet saturates the counter; the following packet must not.
    for (int i = 0; i < 20; i++) applyStimulus(1, 8'h01, 8'h00, 1, (i == 19), 0, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1);
    checkOutput("sat_data", 32'(out_data), 32'h0);
    checkOutput("sat_beats", 32'(out_beats), 32'hF);
    checkOutput("sat_flag", 32'(out_sat), 32'd1);
    applyStimulus(1, 8'h02, 8'h01, 1, 0, 0, 1);
    applyStimulus(1, 8'h04, 8'h00, 1, 1, 0, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1);
    checkOutput("sat_next", 32'(out_sat), 32'd0);

    // Clear mid-packet discards earlier beats.
    applyStimulus(1, 8'h12, 8'h34, 1, 0, 0, 1);
    applyStimulus(1, 8'h56, 8'h78, 1, 0, 0, 1);
    applyStimulus(1, 8'hAA, 8'h00, 1, 1, 1, 1);
    applyStimulus(1, 8'hFF, 8'h00, 1, 1, 0, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1);
    checkOutput("clr_data", 32'(out_data), 32'h000000FF);
    checkOutput("clr_beats", 32'(out_beats), 32'd1);

    // Random traffic with occasional clears and backpressure.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 3) != 0);

    // Asynchronous reset in the middle of an open packet with a result pending.
    applyStimulus(1, 8'h11, 8'h22, 1, 0, 0, 0);
    applyStimulus(1, 8'h33, 8'h44, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 0; clr = 0; out_ready = 0;
    #2 resetb = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_parity", 32'(out_parity), 32'd0);
    checkOutput("rst_beats", 32'(out_beats), 32'd0);
    checkOutput("rst_sat", 32'(out_sat), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    expq.delete(); pkt.delete(); in_pkt = 0;
    @(negedge clk);
    resetb = 1'b1;
    applyStimulus(1, 8'h01, 8'h00, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1);
    checkOutput("post_rst", 32'(out_data), 32'h1);
    for (int i = 0; i < 100; i++)
      applyStimulus($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 1'($urandom),
                    $urandom_range(0, 4) == 0, 1'b0, $urandom_range(0, 1) == 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/xor_accum_pipe.md
Name: xor_accum_pipe

Overview:
Parametrised successor to the single-bit registered XOR cell. Takes WIDTH-bit operand pairs over a valid/ready handshake and operates in one of two modes. Pairwise mode registers a^b per beat. Accumulate mode folds a^b across a multi-beat packet and emits one result on the last beat. Sits between operand producers and checksum/parity consumers in the datapath.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
CNT_W, 4, beat-counter width; counter saturates at 2^CNT_W-1

Ports:
clk  input  1  clock, all state on rising edge
resetb  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear of partial packet
mode  input  1  0 = pairwise, 1 = accumulate; sampled on first beat of packet
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_last  input  1  final beat of packet (ignored in pairwise mode)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result
out_parity  output  1  reduction XOR of out_data, registered with it
out_beats  output  CNT_W  beats folded into result, saturated
out_sat  output  1  beat count saturated during this packet

Behaviour:
- Reset (resetb low, async): out_valid=0, out_data=0, out_parity=0, out_beats=0, out_sat=0, acc=0, cnt=0, state=IDLE. Any partial packet is discarded.
- in_ready = (!out_valid || out_ready) && !clr. This is combinational and equals 1 out of reset. Beat accepted = in_valid && in_ready.
- Output register: loads only on a result-producing accept. Holds stable while out_valid && !out_ready. out_valid clears on out_ready when no new result loads the same cycle.
- Simultaneous drain and load: new result loads and out_valid stays 1. Sustained throughput is 1 result/cycle.
- State IDLE, accept with mode=0: result = a^b, beats=1, sat=0. Output next cycle (latency 1). Stay IDLE.
- State IDLE, accept with mode=1 and in_last=1: same as pairwise (single-beat packet).
- State IDLE, accept with mode=1 and in_last=0: acc<=a^b, cnt<=1, sat<=0. Go to ACC. No output.
- State ACC, accept with in_last=0: acc<=acc^a^b, cnt<=cnt+1 saturating. sat sets if cnt already at max. The mode input is ignored.
- State ACC, accept with in_last=1: result = acc^a^b, beats = cnt+1 saturating, sat as above. Output next cycle. acc<=0, cnt<=0. Go to IDLE.
- Saturation: cnt stops at all-ones. out_sat=1 whenever the true beat count exceeded 2^CNT_W-1.
- clr=1: state<=IDLE, acc<=0, cnt<=0, sat<=0. No beat is accepted that cycle. A pending output register is untouched and drains normally.
- out_parity is computed from the value being loaded, so it is never a cycle behind out_data.
- No combinational path from in_* to out_*. The only comb path is out_ready/clr -> in_ready.

Test Plan:
- Reset: hold resetb=0 mid-traffic -> all outputs 0, in_ready=1; release and pairwise beat a=8'h01,b=8'h00 -> out_data=8'h01 next cycle.
- Pairwise: mode=0, a=8'hA5, b=8'h0E, one beat -> next cycle out_valid=1, out_data=8'hAB, out_parity=1, out_beats=1, out_sat=0.
- Accumulate: mode=1, beats (01,02), (04,08), (10,20,last) -> out_valid only after third accept, out_data=8'h3F, out_parity=0, out_beats=3.
- Backpressure: out_ready=0 with result pending -> in_ready=0, out_data stable 5 cycles. Then out_ready=1 with in_valid=1 on 4 pairwise beats -> 4 results in 4 consecutive cycles, none lost or duplicated.
- Saturation: CNT_W=4, 20-beat accumulate packet of (8'h01,8'h00) -> out_data=8'h00, out_beats=4'hF, out_sat=1. The next packet reports out_sat=0.
- clr mid-packet: 2 accumulate beats then clr=1 for one cycle (in_ready=0). Then a single last beat (8'hFF,8'h00) -> out_data=8'hFF, out_beats=1; the earlier beats do not contribute.
